// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the multiplier scheduler.
// The WAIT state exists only when MULT_PIPE_EN is defined.
package mult_sched_pkg;

   localparam int unsigned OPND_W = 16;
   localparam int unsigned PROD_W = 32;
   localparam int unsigned CNT_W  = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
`ifdef MULT_PIPE_EN
      S_WAIT = 2'd3,
`endif
      S_DONE = 2'd2
   } state_e;

   // Completed-operation counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
   endfunction

endpackage

// File: rtl/WallaceTree.sv
// 16x16 unsigned multiplier: partial products folded through a carry-save
// reduction, with a single carry-propagate add at the end.
module WallaceTree (
   input  logic [15:0] MUR,
   input  logic [15:0] MUD,
   output logic [31:0] result
);

   logic [31:0] sum_v;
   logic [31:0] car_v;
   logic [31:0] pp_v;
   logic [31:0] nsum_v;
   logic [31:0] ncar_v;

   always_comb begin
      sum_v  = '0;
      car_v  = '0;
      pp_v   = '0;
      nsum_v = '0;
      ncar_v = '0;
      for (int i = 0; i < 16; i++) begin
         pp_v   = {16'b0, MUR & {16{MUD[i]}}} << i;
         nsum_v = sum_v ^ car_v ^ pp_v;
         // Carries past bit 31 carry weight 2^32 and cannot affect a 32-bit product.
         ncar_v = ((sum_v & car_v) | (sum_v & pp_v) | (car_v & pp_v)) << 1;
         sum_v  = nsum_v;
         car_v  = ncar_v;
      end
      result = sum_v + car_v;
   end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester after last_grant.
module rr_arbiter #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2
) (
   input  logic [N-1:0]   req_i,
   input  logic [IDW-1:0] last_grant_i,
   output logic [N-1:0]   grant_o
);

   logic [IDW-1:0] idx;
   logic           found;

   always_comb begin
      grant_o = '0;
      idx     = '0;
      found   = 1'b0;
      for (int unsigned k = 1; k <= N; k++) begin
         idx = IDW'((32'(last_grant_i) + k) % N);
         if (!found && req_i[idx]) begin
            grant_o[idx] = 1'b1;
            found        = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mult_scheduler.sv
// Shares one WallaceTree among NREQ requesters with round-robin arbitration.
// Define MULT_PIPE_EN to register the product once more (WAIT state, latency 3).
module mult_scheduler
   import mult_sched_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = OPND_W
) (
   input  logic                          Clk,
   input  logic                          Reset,
   input  logic [NREQ-1:0]               req_valid,
   output logic [NREQ-1:0]               req_ready,
   input  logic [NREQ-1:0][W-1:0]        req_mur,
   input  logic [NREQ-1:0][W-1:0]        req_mud,
   output logic                          rsp_valid,
   input  logic                          rsp_ready,
   output logic [$clog2(NREQ)-1:0]       rsp_id,
   output logic [PROD_W-1:0]             rsp_result,
   output logic [CNT_W-1:0]              op_count
);

   localparam int unsigned IDW = $clog2(NREQ);

   state_e              state_q;
   logic [IDW-1:0]      last_grant_q;
   logic [IDW-1:0]      id_q;
   logic [W-1:0]        mur_q;
   logic [W-1:0]        mud_q;
   logic [PROD_W-1:0]   rsp_result_q;
   logic                rsp_valid_q;
   logic [CNT_W-1:0]    op_count_q;
`ifdef MULT_PIPE_EN
   logic [PROD_W-1:0]   prod_q;
`endif

   logic [NREQ-1:0]     grant;
   logic [IDW-1:0]      win_idx;
   logic [PROD_W-1:0]   wt_result;

   rr_arbiter #(
      .N   (NREQ),
      .IDW (IDW)
   ) u_arb (
      .req_i        (req_valid),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   WallaceTree u_mul (
      .MUR    (mur_q),
      .MUD    (mud_q),
      .result (wt_result)
   );

   // One-hot grant to binary requester index.
   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (grant[i]) win_idx = IDW'(i);
      end
   end

   // Grant is offered only while idle, so it responds to req_valid in the same cycle.
   assign req_ready  = (state_q == S_IDLE) ? grant : '0;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_id     = id_q;
   assign rsp_result = rsp_result_q;
   assign op_count   = op_count_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         id_q         <= '0;
         mur_q        <= '0;
         mud_q        <= '0;
         rsp_result_q <= '0;
         rsp_valid_q  <= 1'b0;
         op_count_q   <= '0;
`ifdef MULT_PIPE_EN
         prod_q       <= '0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (|grant) begin
                  mur_q        <= req_mur[win_idx];
                  mud_q        <= req_mud[win_idx];
                  id_q         <= win_idx;
                  last_grant_q <= win_idx;
                  state_q      <= S_CALC;
               end
            end
            S_CALC: begin
`ifdef MULT_PIPE_EN
               prod_q       <= wt_result;
               state_q      <= S_WAIT;
`else
               rsp_result_q <= wt_result;
               rsp_valid_q  <= 1'b1;
               state_q      <= S_DONE;
`endif
            end
`ifdef MULT_PIPE_EN
            S_WAIT: begin
               rsp_result_q <= prod_q;
               rsp_valid_q  <= 1'b1;
               state_q      <= S_DONE;
            end
`endif
            S_DONE: begin
               // Returning to IDLE first keeps a grant out of the accept cycle.
               if (rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  op_count_q  <= sat_inc(op_count_q);
                  state_q     <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mult_scheduler.sv
// Randomized self-checking bench for mult_scheduler against a transaction-level
// model (round-robin choice, fixed latency, plain multiplication).
module tb_mult_scheduler;

   localparam int N = 4;
`ifdef MULT_PIPE_EN
   localparam int LAT = 3;
`else
   localparam int LAT = 2;
`endif

   logic                 Clk;
   logic                 Reset;
   logic [N-1:0]         req_valid;
   logic [N-1:0]         req_ready;
   logic [N-1:0][15:0]   req_mur;
   logic [N-1:0][15:0]   req_mud;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [1:0]           rsp_id;
   logic [31:0]          rsp_result;
   logic [15:0]          op_count;

   mult_scheduler #(.NREQ(N), .W(16)) dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_mur    (req_mur),
      .req_mud    (req_mud),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .op_count   (op_count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   int n_cmp = 0;
   int n_err = 0;

   // Next-cycle stimulus, applied at the falling edge by step().
   logic               n_rst;
   logic [N-1:0]       n_v;
   logic [N-1:0][15:0] n_a;
   logic [N-1:0][15:0] n_b;
   logic               n_rr;

   // Model state: scheduler either free or holding one job granted at m_gcyc.
   bit          m_live = 0;
   bit          m_busy = 0;
   bit          m_acc  = 0;
   int          m_gcyc = 0;
   int          m_id   = 0;
   logic [31:0] m_prod = '0;
   int          m_last = N - 1;
   int          m_cnt  = 0;
   int          cyc    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic int pick(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         if (v[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic step();
      int          w;
      bit          exp_valid;
      logic [N-1:0] exp_ready;
      @(negedge Clk);
      Reset     = n_rst;
      req_valid = n_v;
      req_mur   = n_a;
      req_mud   = n_b;
      rsp_ready = n_rr;
      #1;
      w         = m_busy ? -1 : pick(n_v, m_last);
      exp_ready = (w >= 0) ? (N'(1) << w) : '0;
      exp_valid = m_busy && ((cyc - m_gcyc) >= LAT);
      if (!n_rst && m_live) begin
         check("req_ready", 32'(req_ready), 32'(exp_ready));
         check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
         if (exp_valid) begin
            check("rsp_id", 32'(rsp_id), 32'(m_id));
            check("rsp_result", rsp_result, m_prod);
         end
         check("op_count", 32'(op_count), 32'(m_cnt));
      end
      m_acc = 0;
      if (n_rst) begin
         m_busy = 0;
         m_last = N - 1;
         m_cnt  = 0;
         m_live = 1;
      end else if (w >= 0) begin
         m_busy = 1;
         m_gcyc = cyc;
         m_id   = w;
         m_prod = 32'(n_a[w]) * 32'(n_b[w]);
         m_last = w;
         m_acc  = 1;
      end else if (exp_valid && n_rr) begin
         m_busy = 0;
         if (m_cnt < 65535) m_cnt++;
      end
      cyc++;
   endtask

   task automatic wait_grant(input string tag);
      int guard = 0;
      do begin
         step();
         guard++;
      end while (!m_acc && guard < 12);
      if (!m_acc) check(tag, 32'(0), 32'(1));
   endtask

   task automatic do_op(input int r, input logic [15:0] a, input logic [15:0] b);
      n_v    = N'(1) << r;
      n_a[r] = a;
      n_b[r] = b;
      n_rr   = 1'b1;
      wait_grant("op_grant_timeout");
   endtask

   task automatic drain();
      n_v  = '0;
      n_rr = 1'b1;
      repeat (LAT + 2) step();
   endtask

   initial begin
      n_rst = 1'b1; n_v = '0; n_rr = 1'b0;
      for (int i = 0; i < N; i++) begin n_a[i] = '0; n_b[i] = '0; end
      repeat (3) step();
      n_rst = 1'b0;
      step();
      check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
      check("rst_rsp_id", 32'(rsp_id), 32'(0));
      check("rst_rsp_result", rsp_result, 32'(0));
      check("rst_op_count", 32'(op_count), 32'(0));
      check("rst_req_ready", 32'(req_ready), 32'(0));

      // Single request from requester 0.
      do_op(0, 16'd3, 16'd5);
      drain();
      check("single_result", rsp_result, 32'd15);
      check("single_id", 32'(rsp_id), 32'(0));
      check("single_count", 32'(op_count), 32'(1));

      // Operand extremes.
      do_op(1, 16'hFFFF, 16'hFFFF);
      drain();
      check("max_product", rsp_result, 32'hFFFE0001);
      do_op(2, 16'h0000, 16'h1234);
      drain();
      check("zero_product", rsp_result, 32'h0);

      // Fairness from reset with all requesters always asking.
      n_rst = 1'b1; step(); n_rst = 1'b0;
      n_v = '1; n_rr = 1'b1;
      for (int i = 0; i < N; i++) begin
         n_a[i] = 16'($urandom);
         n_b[i] = 16'($urandom);
      end
      for (int k = 0; k < 12; k++) begin
         wait_grant("fair_timeout");
         check("fair_grant", 32'(req_ready), 32'(1) << (k % N));
      end
      drain();

      // Backpressure: hold the response, others still requesting.
      do_op(3, 16'($urandom), 16'($urandom));
      n_v = '1; n_rr = 1'b0;
      repeat (LAT + 5) step();
      check("bp_held_valid", 32'(rsp_valid), 32'(1));
      n_rr = 1'b1;
      step();
      step();
      check("bp_next_grant", 32'(|req_ready), 32'(1));
      drain();

      // Reset while the multiplier is busy.
      n_v = '1;
      wait_grant("calc_grant_timeout");
      n_rst = 1'b1; step(); n_rst = 1'b0;
      step();
      check("midrst_prio", 32'(req_ready), 32'(1));
      check("midrst_valid", 32'(rsp_valid), 32'(0));
      check("midrst_count", 32'(op_count), 32'(0));
      drain();

      // Random traffic with random backpressure and occasional reset.
      for (int c = 0; c < 3000; c++) begin
         n_v   = N'($urandom);
         n_rr  = ($urandom_range(0, 3) != 0);
         n_rst = ($urandom_range(0, 199) == 0);
         for (int i = 0; i < N; i++) begin
            n_a[i] = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
            n_b[i] = 16'($urandom);
         end
         step();
      end
      n_rst = 1'b0;
      drain();

      // Exhaustive 7-bit operand sweep through random requesters.
      for (int a = 0; a < 128; a++) begin
         for (int b = 0; b < 128; b++) begin
            do_op($urandom_range(0, N - 1), 16'(a), 16'(b));
         end
      end
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
